// File: rtl/cover_pkg.sv
// cover_pkg: shared types and helpers for the toggle-cover collector.
//   COVER_IDX_W    : width of an absolute cover index (64)
//   cover_idx_t    : absolute cover index type
//   cover_popcount : number of set bits in a 64-bit vector (0..64)
package cover_pkg;

    localparam int COVER_IDX_W = 64;

    typedef logic [COVER_IDX_W-1:0] cover_idx_t;

    function automatic logic [6:0] cover_popcount(input logic [63:0] vec);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + {6'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cover_lowest_set.sv
// cover_lowest_set: combinational priority encoder, lowest set bit wins.
//   vec   (in)  : candidate vector
//   found (out) : at least one bit of vec is set
//   pos   (out) : bit position of the lowest set bit (0 when found=0)
module cover_lowest_set #(
    parameter int WIDTH = 11
) (
    input  logic [WIDTH-1:0]                             vec,
    output logic                                         found,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] pos
);

    localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    always_comb begin
        found = |vec;
        pos   = '0;
        // Scan from the top down so the last assignment is the lowest bit.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                pos = POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector: consumer of a toggle-cover group's per-cycle hit
// vector. Records first hits in a sticky bitmap and streams each newly hit
// point once, as an absolute index, lowest bit first.
//
// Ports:
//   clock, reset  : single clock, asynchronous active-high reset
//   cover_clear   : (only with COVER_CLEAR_EN) zero the bitmap and pending set
//   valid         : per-cycle hit vector, bit i = point COVER_INDEX+i
//   out_valid     : output slot holds an index
//   out_ready     : sink accepts out_index
//   out_index     : absolute cover index COVER_INDEX + bit position
//   hit_map       : sticky bitmap of points ever hit
//   hit_count     : number of set bits in hit_map
//   all_hit       : every point in the group has been hit
//
// Optional feature macro: COVER_CLEAR_EN (adds the cover_clear input).
//
// Handshake: an index transfers on a clock edge where out_valid & out_ready.
// While out_valid & !out_ready the slot (out_valid, out_index) is frozen;
// out_valid only falls after a transfer, or on reset.
module cover_toggle_collector
    import cover_pkg::*;
#(
    parameter int              WIDTH       = 11,
    parameter longint unsigned COVER_INDEX = 0,
    parameter longint unsigned COVER_TOTAL = 38253
) (
    input  logic                         clock,
    input  logic                         reset,
`ifdef COVER_CLEAR_EN
    input  logic                         cover_clear,
`endif
    input  logic [WIDTH-1:0]             valid,
    output logic                         out_valid,
    input  logic                         out_ready,
    output cover_idx_t                   out_index,
    output logic [WIDTH-1:0]             hit_map,
    output logic [$clog2(WIDTH+1)-1:0]   hit_count,
    output logic                         all_hit
);

    localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE_BIT = WIDTH'(1);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("cover_toggle_collector: WIDTH must be within 1..64");
    end
    if (COVER_INDEX + longint'(WIDTH) > COVER_TOTAL) begin : g_bad_range
        $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end

    logic [WIDTH-1:0] hit_map_q,   hit_map_d;
    logic [WIDTH-1:0] pending_q,   pending_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic             all_hit_q,   all_hit_d;
    logic             out_valid_q, out_valid_d;
    cover_idx_t       out_index_q, out_index_d;

    logic             clear_w;
    logic [WIDTH-1:0] base_map;
    logic [WIDTH-1:0] base_pend;
    logic [CNT_W-1:0] base_cnt;
    logic [WIDTH-1:0] new_hits;
    logic [WIDTH-1:0] merged_pend;
    logic [7:0]       cnt_sum;
    logic             load;
    logic             low_found;
    logic [POS_W-1:0] low_pos;

`ifdef COVER_CLEAR_EN
    assign clear_w = cover_clear;
`else
    assign clear_w = 1'b0;
`endif

    // New hits are merged into pending before the slot picks, so a fresh
    // hit can be loaded in the same edge it arrives and a low fresh hit
    // overtakes higher bits already waiting.
    cover_lowest_set #(
        .WIDTH (WIDTH)
    ) u_lowest (
        .vec   (merged_pend),
        .found (low_found),
        .pos   (low_pos)
    );

    always_comb begin
        // A clear takes effect before this cycle's hits are recorded.
        base_map    = clear_w ? '0 : hit_map_q;
        base_pend   = clear_w ? '0 : pending_q;
        base_cnt    = clear_w ? '0 : hit_count_q;

        new_hits    = valid & ~base_map;
        hit_map_d   = base_map | new_hits;
        merged_pend = base_pend | new_hits;
        all_hit_d   = &hit_map_d;

        cnt_sum     = 8'(base_cnt) + 8'(cover_popcount(64'(new_hits)));
        hit_count_d = (cnt_sum > 8'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(cnt_sum);

        // The slot refills when empty or when its content leaves this edge.
        load        = !out_valid_q || out_ready;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        pending_d   = merged_pend;
        if (load) begin
            out_valid_d = low_found;
            if (low_found) begin
                out_index_d = cover_idx_t'(COVER_INDEX) + cover_idx_t'(low_pos);
                pending_d   = merged_pend & ~(ONE_BIT << low_pos);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_map_q   <= '0;
            pending_q   <= '0;
            hit_count_q <= '0;
            all_hit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
        end else begin
            hit_map_q   <= hit_map_d;
            pending_q   <= pending_d;
            hit_count_q <= hit_count_d;
            all_hit_q   <= all_hit_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign hit_map   = hit_map_q;
    assign hit_count = hit_count_q;
    assign all_hit   = all_hit_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Bench for cover_toggle_collector (WIDTH=11, COVER_INDEX=100).
// Build with +define+COVER_CLEAR_EN to also exercise cover_clear.
module tb_cover_toggle_collector;

    localparam int              W  = 11;
    localparam longint unsigned CI = 100;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  valid = '0;
    logic          out_ready = 1'b0;
    logic          cover_clear = 1'b0;
    logic          out_valid;
    logic [63:0]   out_index;
    logic [W-1:0]  hit_map;
    logic [3:0]    hit_count;
    logic          all_hit;

    always #5 clock = ~clock;

    cover_toggle_collector #(
        .WIDTH       (W),
        .COVER_INDEX (CI),
        .COVER_TOTAL (38253)
    ) dut (
        .clock       (clock),
        .reset       (reset),
`ifdef COVER_CLEAR_EN
        .cover_clear (cover_clear),
`endif
        .valid       (valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .hit_map     (hit_map),
        .hit_count   (hit_count),
        .all_hit     (all_hit)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: set of points ever hit, set of points still owed to
    // the sink, and the one index currently offered.
    bit          m_hit[W];
    bit          m_pend[W];
    bit          m_sv;
    logic [63:0] m_idx;

    function automatic void model_reset();
        for (int i = 0; i < W; i++) begin
            m_hit[i]  = 0;
            m_pend[i] = 0;
        end
        m_sv  = 0;
        m_idx = '0;
    endfunction

    function automatic void model_step(input logic [W-1:0] v, input bit rdy, input bit clr);
        bit fire;
        fire = m_sv && rdy;
        if (clr) begin
            for (int i = 0; i < W; i++) begin
                m_hit[i]  = 0;
                m_pend[i] = 0;
            end
        end
        for (int i = 0; i < W; i++) begin
            if (v[i] && !m_hit[i]) begin
                m_hit[i]  = 1;
                m_pend[i] = 1;
            end
        end
        if (!m_sv || fire) begin
            m_sv = 0;
            for (int i = 0; i < W; i++) begin
                if (m_pend[i]) begin
                    m_sv      = 1;
                    m_idx     = CI + 64'(i);
                    m_pend[i] = 0;
                    break;
                end
            end
        end
    endfunction

    task automatic check_model();
        logic [W-1:0] hm;
        int cnt;
        cnt = 0;
        for (int i = 0; i < W; i++) begin
            hm[i] = m_hit[i];
            cnt += int'(m_hit[i]);
        end
        check("model out_valid", 64'(out_valid), 64'(m_sv));
        if (m_sv) check("model out_index", out_index, m_idx);
        check("model hit_map", 64'(hit_map), 64'(hm));
        check("model hit_count", 64'(hit_count), 64'(cnt));
        check("model all_hit", 64'(all_hit), 64'(cnt == W));
    endtask

    // One clock: drive at the falling edge, log any transfer that the
    // coming rising edge will complete, then compare just after that edge.
    task automatic step(input logic [W-1:0] v, input bit rdy, input bit clr);
        @(negedge clock);
        valid       = v;
        out_ready   = rdy;
        cover_clear = clr;
        #1;
        if (out_valid && rdy) got_q.push_back(out_index);
        @(posedge clock);
        model_step(v, rdy, clr);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        valid     = W'($urandom);
        out_ready = 1'($urandom);
        #1;
        model_reset();
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_index", out_index, 64'd0);
        check("reset hit_map", 64'(hit_map), 64'd0);
        check("reset hit_count", 64'(hit_count), 64'd0);
        check("reset all_hit", 64'(all_hit), 64'd0);
        @(posedge clock);
        #1;
        check("reset ignores valid", 64'(hit_map), 64'd0);
        @(negedge clock);
        reset       = 1'b0;
        valid       = '0;
        cover_clear = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_seq(input string name);
        check({name, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({name, " index"}, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        bit          rst;
        logic [W-1:0] v;
        bit          rdy;
        bit          ov;
        logic [63:0] idx;
        int          cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit rst, input logic [W-1:0] v, input bit rdy,
                                input bit ov, input logic [63:0] idx, input int cnt);
        vec_t r;
        r.rst = rst; r.v = v; r.rdy = rdy; r.ov = ov; r.idx = idx; r.cnt = cnt;
        tbl.push_back(r);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Drain order
        add(1, '0, 0, 0, 0, 0);
        add(0, 11'h025, 1, 1, 100, 3);
        add(0, 11'h000, 1, 1, 102, 3);
        add(0, 11'h000, 1, 1, 105, 3);
        add(0, 11'h000, 1, 0, 0, 3);
        // Repeat toggles of one point
        add(1, '0, 0, 0, 0, 0);
        add(0, 11'h001, 1, 1, 100, 1);
        for (int i = 0; i < 4; i++) add(0, 11'h001, 1, 0, 0, 1);
        // Slot holds 3, pending {5,7}; a hit on 1 arrives with the drain
        add(1, '0, 0, 0, 0, 0);
        add(0, 11'h0A8, 0, 1, 103, 3);
        add(0, 11'h002, 1, 1, 101, 4);
        add(0, 11'h000, 1, 1, 105, 4);
        add(0, 11'h000, 1, 1, 107, 4);
        add(0, 11'h000, 1, 0, 0, 4);

        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) begin
                do_reset();
            end else begin
                step(tbl[i].v, tbl[i].rdy, 1'b0);
                check($sformatf("tbl[%0d] out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
                if (tbl[i].ov) check($sformatf("tbl[%0d] out_index", i), out_index, tbl[i].idx);
                check($sformatf("tbl[%0d] hit_count", i), 64'(hit_count), 64'(tbl[i].cnt));
            end
        end

        // Backpressure then full drain
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(11'h7FF, 1'b0, 1'b0);
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp out_index", out_index, 64'd100);
        end
        for (int i = 0; i < W; i++) exp_q.push_back(CI + 64'(i));
        for (int i = 0; i < 12; i++) step('0, 1'b1, 1'b0);
        check_seq("bp drain");
        check("bp all_hit", 64'(all_hit), 64'd1);
        check("bp hit_count", 64'(hit_count), 64'd11);
        check("bp idle", 64'(out_valid), 64'd0);

        // Reset in the middle of a drain
        do_reset();
        step(11'h00F, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);
        check("mid out_index", out_index, 64'd101);
        do_reset();
        step(11'h001, 1'b1, 1'b0);
        check("mid re-hit out_valid", 64'(out_valid), 64'd1);
        check("mid re-hit out_index", out_index, 64'd100);

`ifdef COVER_CLEAR_EN
        do_reset();
        step(11'h001, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b1);
        check("clr hit_count", 64'(hit_count), 64'd0);
        step(11'h001, 1'b1, 1'b0);
        check("clr re-emit", out_index, 64'd100);
        check("clr hit_count 1", 64'(hit_count), 64'd1);
        // Clear under backpressure keeps the offered index
        do_reset();
        step(11'h003, 1'b0, 1'b0);
        step(11'h004, 1'b0, 1'b1);
        check("clr bp out_index", out_index, 64'd100);
        check("clr bp hit_map", 64'(hit_map), 64'h004);
`endif

        // Randomised traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] v;
            bit rdy, clr;
            v   = ($urandom_range(0, 2) == 0) ? W'($urandom & $urandom) : '0;
            rdy = ($urandom_range(0, 3) != 0);
            clr = 1'b0;
`ifdef COVER_CLEAR_EN
            clr = ($urandom_range(0, 39) == 0);
`endif
            if ($urandom_range(0, 79) == 0) do_reset();
            else step(v, rdy, clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
